control_sequencer: RTL

Hardwired control unit that drives the bus-based datapath: it steps through fetch, decode and execute states and produces every one-hot register-enable, bus-drive, ALU-opcode and memory-handshake signal the datapath consumes. It receives only the instruction register contents and a memory acknowledge. It sits beside the datapath at the top level, and its outputs connect one-to-one to the datapath control inputs.

---
 rtl/control_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit for the bus-based datapath.
// Define CU_MULDIV_EN to enable the MUL/DIV (op 5'h0E/5'h0F) sequences.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ack,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        PCout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDR_read,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic [4:0]  control,
  output logic        mem_rd,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_ALU_MAX = 5'h0B;
  localparam logic [4:0] OP_MUL     = 5'h0E;
  localparam logic [4:0] OP_DIV     = 5'h0F;
  localparam logic [4:0] OP_MFHI    = 5'h10;
  localparam logic [4:0] OP_MFLO    = 5'h11;
  localparam logic [4:0] OP_NOP     = 5'h12;
  localparam logic [4:0] OP_HALT    = 5'h13;
  localparam logic [4:0] ALU_INC    = 5'h1F;

  state_t state_reg, state_next;

  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic [15:0] ra_hot, rb_hot, rc_hot;
  logic        is_alu, is_muldiv;
  logic        unused_ir_bits;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_ir_bits = ^ir[14:0];

  for (genvar gi = 0; gi < 16; gi++) begin : g_hot
    assign ra_hot[gi] = (ra == 4'(gi));
    assign rb_hot[gi] = (rb == 4'(gi));
    assign rc_hot[gi] = (rc == 4'(gi));
  end

  assign is_alu = (op <= OP_ALU_MAX);
`ifdef CU_MULDIV_EN
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
`else
  assign is_muldiv = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clr) state_reg <= S_T0;
    else      state_reg <= state_next;
  end

  // Outputs are forced low combinationally while clr is held, so the
  // T0 strobes appear in the very cycle clr is released.
  always_comb begin
    state_next = state_reg;
    reg_in     = 16'h0000;
    reg_out    = 16'h0000;
    PCout      = 1'b0;
    PCin       = 1'b0;
    IRin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    MDR_read   = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    HIin       = 1'b0;
    HIout      = 1'b0;
    LOin       = 1'b0;
    LOout      = 1'b0;
    control    = 5'h00;
    mem_rd     = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (clr) begin
      case (state_reg)
        S_T0: begin
          PCout      = 1'b1;
          MARin      = 1'b1;
          control    = ALU_INC;
          Zin        = 1'b1;
          state_next = S_T1;
        end
        S_T1: begin
          Zlowout    = 1'b1;
          PCin       = 1'b1;
          mem_rd     = 1'b1;
          state_next = S_T2;
        end
        S_T2: begin
          mem_rd     = 1'b1;
          MDR_read   = 1'b1;
          MDRin      = mem_ack;
          state_next = mem_ack ? S_T3 : S_T2;
        end
        S_T3: begin
          MDRout     = 1'b1;
          IRin       = 1'b1;
          state_next = S_T4;
        end
        S_T4: begin
          state_next = S_T0;
          if (is_alu) begin
            reg_out    = rb_hot;
            Yin        = 1'b1;
            state_next = S_T5;
          end else if (is_muldiv) begin
            reg_out    = ra_hot;
            Yin        = 1'b1;
            state_next = S_T5;
          end else if (op == OP_MFHI) begin
            HIout  = 1'b1;
            reg_in = ra_hot;
          end else if (op == OP_MFLO) begin
            LOout  = 1'b1;
            reg_in = ra_hot;
          end else if (op == OP_HALT) begin
            state_next = S_HALT;
          end else if (op != OP_NOP) begin
            illegal = 1'b1;
          end
        end
        S_T5: begin
          state_next = S_T0;
          if (is_alu || is_muldiv) begin
            reg_out    = is_alu ? rc_hot : rb_hot;
            control    = op;
            Zin        = 1'b1;
            state_next = S_T6;
          end
        end
        S_T6: begin
          Zlowout    = 1'b1;
          state_next = S_T0;
          if (is_muldiv) begin
            LOin       = 1'b1;
            state_next = S_T7;
          end else begin
            reg_in = ra_hot;
          end
        end
        S_T7: begin
          Zhighout   = 1'b1;
          HIin       = 1'b1;
          state_next = S_T0;
        end
        S_HALT: begin
          halted     = 1'b1;
          state_next = S_HALT;
        end
        default: state_next = S_T0;
      endcase
    end
  end

endmodule
